// File: rtl/s1_cfg_loader_if.sv
// s1_cfg_loader_if: serial bitstream handshake plus committed configuration bus
interface s1_cfg_loader_if #(parameter int NCELLS = 8);
  logic start;
  logic bit_in;
  logic bit_valid;
  logic bit_ready;
  logic [4*NCELLS-1:0] cfg;
  logic cfg_valid;
  logic busy;
  logic err;
  modport master(output start, bit_in, bit_valid, input bit_ready, cfg, cfg_valid, busy, err);
  modport slave(input start, bit_in, bit_valid, output bit_ready, cfg, cfg_valid, busy, err);
endinterface

// File: rtl/s1_cfg_loader.sv
// s1_cfg_loader: framed serial loader committing checksum-verified payload into a cell config register
module s1_cfg_loader #(
  parameter int NCELLS = 8,
  parameter logic [7:0] HDR = 8'hA5
) (
  input logic clk,
  input logic clr,
  s1_cfg_loader_if.slave bus
);
  localparam int N = 4 * NCELLS;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_CHK, S_ERR} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [7:0] hdr_sh;
  logic [N-1:0] stage;
  logic [3:0] xacc;
  logic [3:0] chk;
  logic acc;
  assign bus.busy = state == S_HDR || state == S_LOAD || state == S_CHK;
  assign bus.bit_ready = bus.busy;
  assign bus.err = state == S_ERR;
  assign acc = bus.bit_valid && bus.bit_ready;
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= S_IDLE;
      cnt <= '0;
      hdr_sh <= '0;
      stage <= '0;
      xacc <= '0;
      chk <= '0;
      bus.cfg <= '0;
      bus.cfg_valid <= 1'b0;
    end else begin
      bus.cfg_valid <= 1'b0;
      case (state)
        S_IDLE, S_ERR: if (bus.start) begin
          state <= S_HDR;
          cnt <= '0;
        end
        S_HDR: if (acc) begin
          hdr_sh <= {hdr_sh[6:0], bus.bit_in};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(7)) begin
            state <= {hdr_sh[6:0], bus.bit_in} == HDR ? S_LOAD : S_ERR;
            cnt <= '0;
            xacc <= '0;
          end
        end
        S_LOAD: if (acc) begin
          stage <= {stage[N-2:0], bus.bit_in};
          cnt <= cnt + 1'b1;
          if (cnt[1:0] == 2'd3) xacc <= xacc ^ {stage[2:0], bus.bit_in};
          if (cnt == CW'(N - 1)) begin
            state <= S_CHK;
            cnt <= '0;
          end
        end
        S_CHK: if (acc) begin
          chk <= {chk[2:0], bus.bit_in};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(3)) begin
            cnt <= '0;
            if ({chk[2:0], bus.bit_in} == xacc) begin
              bus.cfg <= stage;
              bus.cfg_valid <= 1'b1;
              state <= S_IDLE;
            end else state <= S_ERR;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_s1_cfg_loader.sv
// tb_s1_cfg_loader: directed self-checking bench for the serial config loader
module tb_s1_cfg_loader;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int pass_cnt = 0;
  int total_cnt = 0;
  int pulses = 0;
  s1_cfg_loader_if #(.NCELLS(2)) bus();
  s1_cfg_loader #(.NCELLS(2), .HDR(8'hA5)) dut(.clk(clk), .clr(clr), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.cfg_valid) pulses++;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask
  task automatic send_bits(input logic [7:0] v, input int n, input int max_stall, input int gap_at);
    for (int i = n - 1; i >= 0; i--) begin
      int st;
      st = (max_stall > 0 ? int'($urandom_range(0, max_stall)) : 0) + (i == gap_at ? 5 : 0);
      for (int k = 0; k < st; k++) begin
        bus.bit_valid = 1'b0;
        bus.bit_in = ~v[i];
        tick();
      end
      bus.bit_valid = 1'b1;
      bus.bit_in = v[i];
      tick();
    end
    bus.bit_valid = 1'b0;
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic test_reset();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    chk("reset_cfg", 32'(bus.cfg), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_err", 32'(bus.err), 0);
    chk("reset_ready", 32'(bus.bit_ready), 0);
    chk("reset_valid", 32'(bus.cfg_valid), 0);
  endtask
  task automatic test_normal();
    pulse_start();
    chk("norm_busy", 32'(bus.busy), 1);
    send_bits(8'hA5, 8, 0, -1);
    chk("norm_ready_load", 32'(bus.bit_ready), 1);
    send_bits(8'hB6, 8, 0, -1);
    send_bits(8'h0D, 4, 0, -1);
    chk("norm_cfg", 32'(bus.cfg), 32'hB6);
    chk("norm_valid", 32'(bus.cfg_valid), 1);
    chk("norm_busy_after", 32'(bus.busy), 0);
    tick();
    chk("norm_valid_one_cycle", 32'(bus.cfg_valid), 0);
  endtask
  task automatic test_bad_checksum();
    int p0;
    p0 = pulses;
    pulse_start();
    send_bits(8'hA5, 8, 0, -1);
    send_bits(8'h3C, 8, 0, -1);
    send_bits(8'h00, 4, 0, -1);
    chk("badck_err", 32'(bus.err), 1);
    chk("badck_ready", 32'(bus.bit_ready), 0);
    chk("badck_cfg", 32'(bus.cfg), 32'hB6);
    tick();
    chk("badck_no_pulse", 32'(pulses), 32'(p0));
  endtask
  task automatic test_bad_header_recovery();
    pulse_start();
    chk("hdr_err_cleared_1", 32'(bus.err), 0);
    send_bits(8'hA4, 8, 0, -1);
    chk("hdr_err", 32'(bus.err), 1);
    chk("hdr_ready", 32'(bus.bit_ready), 0);
    chk("hdr_cfg_kept", 32'(bus.cfg), 32'hB6);
    pulse_start();
    chk("hdr_err_cleared_2", 32'(bus.err), 0);
    send_bits(8'hA5, 8, 0, -1);
    send_bits(8'h5A, 8, 0, -1);
    send_bits(8'h0F, 4, 0, -1);
    chk("rec_cfg", 32'(bus.cfg), 32'h5A);
    chk("rec_valid", 32'(bus.cfg_valid), 1);
    chk("rec_err", 32'(bus.err), 0);
  endtask
  task automatic test_stalls();
    pulse_start();
    send_bits(8'hA5, 8, 2, -1);
    send_bits(8'hB6, 8, 2, 3);
    chk("stall_busy", 32'(bus.busy), 1);
    send_bits(8'h0D, 4, 2, -1);
    chk("stall_cfg", 32'(bus.cfg), 32'hB6);
    chk("stall_valid", 32'(bus.cfg_valid), 1);
    tick();
    chk("stall_valid_one_cycle", 32'(bus.cfg_valid), 0);
  endtask
  task automatic test_reset_mid();
    int p0;
    pulse_start();
    send_bits(8'hA5, 8, 0, -1);
    send_bits(8'h05, 3, 0, -1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("rmid_cfg", 32'(bus.cfg), 0);
    chk("rmid_busy", 32'(bus.busy), 0);
    chk("rmid_err", 32'(bus.err), 0);
    chk("rmid_ready", 32'(bus.bit_ready), 0);
    p0 = pulses;
    send_bits(8'hA5, 8, 0, -1);
    send_bits(8'hB6, 8, 0, -1);
    send_bits(8'h0D, 4, 0, -1);
    tick();
    chk("rmid_ignored_busy", 32'(bus.busy), 0);
    chk("rmid_ignored_cfg", 32'(bus.cfg), 0);
    chk("rmid_ignored_pulse", 32'(pulses), 32'(p0));
  endtask
  task automatic test_start_busy();
    int p0;
    p0 = pulses;
    pulse_start();
    send_bits(8'hA5, 8, 0, -1);
    send_bits(8'h09, 4, 0, -1);
    pulse_start();
    chk("sb_busy", 32'(bus.busy), 1);
    send_bits(8'h06, 4, 0, -1);
    send_bits(8'h0F, 4, 0, -1);
    chk("sb_cfg", 32'(bus.cfg), 32'h96);
    chk("sb_valid", 32'(bus.cfg_valid), 1);
    chk("sb_err", 32'(bus.err), 0);
    tick();
    chk("sb_valid_one_cycle", 32'(bus.cfg_valid), 0);
    chk("sb_one_pulse", 32'(pulses), 32'(p0 + 1));
  endtask
  initial begin
    bus.start = 1'b0;
    bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0;
    test_reset();
    test_normal();
    test_bad_checksum();
    test_bad_header_recovery();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    test_stalls();
    test_reset_mid();
    test_start_busy();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
